// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage MIPS pipeline
//   inputs : Decode sources/branch/jump/hilo flags, Execute and Memory destination
//            and control bits, mul/div issue, data-memory wait request
//   outputs: stall_* hold the FD/DE/EM/MW registers, clear_* insert bubbles,
//            muldiv_busy while the mul/div countdown runs, stall_cycles counter
module pipeline_hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_decode,
  input  logic [4:0]  rt_decode,
  input  logic        branch_decode,
  input  logic        branch_taken_decode,
  input  logic        jump_decode,
  input  logic        hilo_read_decode,
  input  logic [4:0]  write_reg_execute,
  input  logic        reg_write_execute,
  input  logic        mem_to_reg_execute,
  input  logic [4:0]  write_reg_memory,
  input  logic        mem_to_reg_memory,
  input  logic        muldiv_start_execute,
  input  logic        muldiv_is_div,
  input  logic        dmem_waitrequest,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        stall_memory,
  output logic        clear_decode,
  output logic        clear_execute,
  output logic        clear_writeback,
  output logic        muldiv_busy,
  output logic [15:0] stall_cycles
);
  logic [CNT_WIDTH-1:0] cnt;
  logic busy, hit_e, hit_m, load_use, branch_hz, hilo_hz, freeze, dstall, flush;
  assign busy      = cnt != '0;
  assign hit_e     = write_reg_execute != 5'd0 && (write_reg_execute == rs_decode || write_reg_execute == rt_decode);
  assign hit_m     = write_reg_memory != 5'd0 && (write_reg_memory == rs_decode || write_reg_memory == rt_decode);
  assign load_use  = mem_to_reg_execute && hit_e;
  assign branch_hz = (branch_decode || jump_decode) && ((reg_write_execute && hit_e) || (mem_to_reg_memory && hit_m));
  assign hilo_hz   = hilo_read_decode && (busy || muldiv_start_execute);
  assign freeze    = dmem_waitrequest;
  assign dstall    = load_use || branch_hz || hilo_hz;
  assign flush     = (branch_taken_decode && branch_decode) || jump_decode;
  always_comb begin
    stall_fetch     = !reset && (freeze || dstall);
    stall_decode    = !reset && (freeze || dstall);
    stall_execute   = !reset && freeze;
    stall_memory    = !reset && freeze;
    clear_writeback = !reset && freeze;
    clear_execute   = !reset && !freeze && dstall;
    clear_decode    = !reset && !freeze && !dstall && flush;
    muldiv_busy     = !reset && busy;
  end
  // the unit keeps counting through freezes; a start only issues when Execute moves
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (muldiv_start_execute && !stall_execute) cnt <= muldiv_is_div ? CNT_WIDTH'(DIV_CYCLES) : CNT_WIDTH'(MULT_CYCLES);
    else if (busy) cnt <= cnt - 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cycles <= '0;
    else if (stall_fetch && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of the hazard controller
module tb_pipeline_hazard_controller;
  logic clk = 0, reset = 1;
  logic [4:0] rs_decode, rt_decode, write_reg_execute, write_reg_memory;
  logic branch_decode, branch_taken_decode, jump_decode, hilo_read_decode;
  logic reg_write_execute, mem_to_reg_execute, mem_to_reg_memory;
  logic muldiv_start_execute, muldiv_is_div, dmem_waitrequest;
  logic stall_fetch, stall_decode, stall_execute, stall_memory;
  logic clear_decode, clear_execute, clear_writeback, muldiv_busy;
  logic [15:0] stall_cycles;
  logic [6:0] o;
  int checks = 0, failures = 0;
  localparam logic [6:0] NONE = 7'b0000000, DST = 7'b1100010, FRZ = 7'b1111001, FLU = 7'b0000100;
  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .rs_decode(rs_decode), .rt_decode(rt_decode),
    .branch_decode(branch_decode), .branch_taken_decode(branch_taken_decode),
    .jump_decode(jump_decode), .hilo_read_decode(hilo_read_decode),
    .write_reg_execute(write_reg_execute), .reg_write_execute(reg_write_execute),
    .mem_to_reg_execute(mem_to_reg_execute), .write_reg_memory(write_reg_memory),
    .mem_to_reg_memory(mem_to_reg_memory), .muldiv_start_execute(muldiv_start_execute),
    .muldiv_is_div(muldiv_is_div), .dmem_waitrequest(dmem_waitrequest),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memory(stall_memory), .clear_decode(clear_decode), .clear_execute(clear_execute),
    .clear_writeback(clear_writeback), .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );
  assign o = {stall_fetch, stall_decode, stall_execute, stall_memory, clear_decode, clear_execute, clear_writeback};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {rs_decode, rt_decode, write_reg_execute, write_reg_memory} = '0;
    {branch_decode, branch_taken_decode, jump_decode, hilo_read_decode} = '0;
    {reg_write_execute, mem_to_reg_execute, mem_to_reg_memory} = '0;
    {muldiv_start_execute, muldiv_is_div, dmem_waitrequest} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    dmem_waitrequest = 1;
    hilo_read_decode = 1;
    tick(); tick();
    #1;
    chk("rst_outs", o, NONE);
    chk("rst_busy", muldiv_busy, 0);
    chk("rst_cnt", stall_cycles, 0);
    idle();
    reset = 0;
    tick();
    // load-use
    mem_to_reg_execute = 1; reg_write_execute = 1; write_reg_execute = 8; rs_decode = 8;
    #1 chk("lu_stall", o, DST);
    tick();
    idle(); rs_decode = 8; mem_to_reg_memory = 1; write_reg_memory = 8;
    #1 chk("lu_release", o, NONE);
    chk("lu_cnt", stall_cycles, 1);
    tick();
    // taken branch without hazard
    idle(); branch_decode = 1; branch_taken_decode = 1; rs_decode = 3; rt_decode = 4;
    #1 chk("br_flush", o, FLU);
    tick();
    idle();
    #1 chk("br_after", o, NONE);
    chk("br_cnt", stall_cycles, 1);
    tick();
    // branch after load: two stall cycles then flush
    branch_decode = 1; branch_taken_decode = 1; rt_decode = 9;
    mem_to_reg_execute = 1; reg_write_execute = 1; write_reg_execute = 9;
    #1 chk("bl_stall1", o, DST);
    tick();
    mem_to_reg_execute = 0; reg_write_execute = 0; write_reg_execute = 0;
    mem_to_reg_memory = 1; write_reg_memory = 9;
    #1 chk("bl_stall2", o, DST);
    tick();
    mem_to_reg_memory = 0; write_reg_memory = 0;
    #1 chk("bl_flush", o, FLU);
    chk("bl_cnt", stall_cycles, 3);
    tick();
    // branch with ALU producer in Execute: one cycle
    idle(); branch_decode = 1; rs_decode = 5; reg_write_execute = 1; write_reg_execute = 5;
    #1 chk("ba_stall", o, DST);
    tick();
    reg_write_execute = 0; write_reg_execute = 0;
    #1 chk("ba_release", o, NONE);
    tick();
    // divide then MFLO
    idle(); muldiv_start_execute = 1; muldiv_is_div = 1;
    #1 chk("div_pre", muldiv_busy, 0);
    tick();
    idle(); hilo_read_decode = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("div_busy%0d", i), muldiv_busy, 1);
      chk($sformatf("div_stall%0d", i), o, DST);
      tick();
    end
    #1 chk("div_done", muldiv_busy, 0);
    chk("div_release", o, NONE);
    chk("div_cnt", stall_cycles, 36);
    tick();
    // multiply issued together with MFHI in Decode
    idle(); muldiv_start_execute = 1; hilo_read_decode = 1;
    #1 chk("mul_start_hz", o, DST);
    tick();
    muldiv_start_execute = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mul_busy%0d", i), muldiv_busy, 1);
      tick();
    end
    #1 chk("mul_done", muldiv_busy, 0);
    chk("mul_release", o, NONE);
    chk("mul_cnt", stall_cycles, 41);
    tick();
    // freeze over a load-use hazard; a start during freeze must not issue
    idle(); mem_to_reg_execute = 1; write_reg_execute = 7; rt_decode = 7; dmem_waitrequest = 1;
    muldiv_start_execute = 1; muldiv_is_div = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("frz%0d", i), o, FRZ);
      tick();
      muldiv_start_execute = 0;
    end
    chk("frz_nostart", muldiv_busy, 0);
    dmem_waitrequest = 0;
    #1 chk("frz_lu", o, DST);
    tick();
    idle();
    #1 chk("frz_release", o, NONE);
    chk("frz_cnt", stall_cycles, 45);
    // reset mid-divide at countdown 20
    muldiv_start_execute = 1; muldiv_is_div = 1;
    tick();
    idle();
    for (int i = 0; i < 12; i++) tick();
    chk("rd_busy", muldiv_busy, 1);
    hilo_read_decode = 1; dmem_waitrequest = 1;
    reset = 1;
    #1 chk("rd_busy0", muldiv_busy, 0);
    chk("rd_outs", o, NONE);
    chk("rd_cnt", stall_cycles, 0);
    tick();
    reset = 0;
    idle();
    tick();
    chk("rd_stay", muldiv_busy, 0);
    // register 0 never hazards
    mem_to_reg_execute = 1; reg_write_execute = 1; write_reg_execute = 0; rs_decode = 0;
    #1 chk("r0_lu", o, NONE);
    idle(); branch_decode = 1; mem_to_reg_memory = 1; write_reg_memory = 0;
    #1 chk("r0_br", o, NONE);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
